// File: rtl/bp_pkg.sv
// Shared constants and types for the branch statistics profiler.
package bp_pkg;

  localparam int ID_W   = 3;
  localparam int NUM_BR = 1 << ID_W;
  localparam int CNT_W  = 16;
  localparam int LOST_W = 8;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [LOST_W-1:0] LOST_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    DUMP,
    CLEAR
  } prof_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable and synchronous clear.
// Clear wins over increment; the count sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  import bp_pkg::*;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_miss_profiler.sv
// Per-branch and global execution/miss/taken statistics with a valid/ready dump that
// clears the counters afterwards; events arriving during a dump only bump 'lost'.
module branch_miss_profiler #(
  parameter int NUM_BR = bp_pkg::NUM_BR,
  parameter int ID_W   = bp_pkg::ID_W,
  parameter int CNT_W  = bp_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ev_valid,
  input  logic [ID_W-1:0]  branchID,
  input  logic             outcome,
  input  logic             miss,
  input  logic             dump_req,
  input  logic             dump_ready,
  output logic             dump_valid,
  output logic [ID_W-1:0]  dump_id,
  output logic [CNT_W-1:0] dump_exec,
  output logic [CNT_W-1:0] dump_miss,
  output logic [CNT_W-1:0] dump_taken,
  output logic [CNT_W-1:0] total_exec,
  output logic [CNT_W-1:0] total_miss,
  output logic [7:0]       lost,
  output logic             busy
);
  import bp_pkg::*;

  prof_state_t     state_q, state_d;
  logic [ID_W-1:0] idx_q, idx_d;

  logic [CNT_W-1:0] exec_cnt  [NUM_BR];
  logic [CNT_W-1:0] miss_cnt  [NUM_BR];
  logic [CNT_W-1:0] taken_cnt [NUM_BR];

  logic count_en, drop_en, clr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (dump_req) begin
          state_d = DUMP;
          idx_d   = '0;
        end
      end
      DUMP: begin
        if (dump_ready) begin
          // index wraps to 0 on the last entry, so IDLE always shows id 0
          idx_d = idx_q + ID_W'(1);
          if (idx_q == ID_W'(NUM_BR - 1)) begin
            state_d = CLEAR;
          end
        end
      end
      CLEAR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign count_en = ev_valid && (state_q == IDLE);
  assign drop_en  = ev_valid && (state_q != IDLE);
  assign clr      = (state_q == CLEAR);

  for (genvar g = 0; g < NUM_BR; g++) begin : g_br
    logic hit;
    assign hit = count_en && (branchID == ID_W'(g));

    sat_counter #(.W(CNT_W)) u_exec (
      .clk(clk), .reset(reset), .clr_i(clr), .inc_i(hit), .cnt_o(exec_cnt[g])
    );
    sat_counter #(.W(CNT_W)) u_miss (
      .clk(clk), .reset(reset), .clr_i(clr), .inc_i(hit && miss), .cnt_o(miss_cnt[g])
    );
    sat_counter #(.W(CNT_W)) u_taken (
      .clk(clk), .reset(reset), .clr_i(clr), .inc_i(hit && outcome), .cnt_o(taken_cnt[g])
    );
  end

  sat_counter #(.W(CNT_W)) u_total_exec (
    .clk(clk), .reset(reset), .clr_i(clr), .inc_i(count_en), .cnt_o(total_exec)
  );
  sat_counter #(.W(CNT_W)) u_total_miss (
    .clk(clk), .reset(reset), .clr_i(clr), .inc_i(count_en && miss), .cnt_o(total_miss)
  );
  // survives CLEAR; only reset zeroes it
  sat_counter #(.W(8)) u_lost (
    .clk(clk), .reset(reset), .clr_i(1'b0), .inc_i(drop_en), .cnt_o(lost)
  );

  assign busy       = (state_q != IDLE);
  assign dump_valid = (state_q == DUMP);
  assign dump_id    = idx_q;
  assign dump_exec  = dump_valid ? exec_cnt[idx_q]  : '0;
  assign dump_miss  = dump_valid ? miss_cnt[idx_q]  : '0;
  assign dump_taken = dump_valid ? taken_cnt[idx_q] : '0;

endmodule

// File: tb/tb_branch_miss_profiler.sv
// Randomised and directed stimulus against a behavioural model; a negedge monitor
// checks totals every cycle and pops expected dump entries as they are accepted.
module tb_branch_miss_profiler;
  import bp_pkg::*;

  localparam int MAXC = 65535;
  localparam int MAXL = 255;

  logic             clk = 1'b0;
  logic             reset;
  logic             ev_valid;
  logic [ID_W-1:0]  branchID;
  logic             outcome;
  logic             miss;
  logic             dump_req;
  logic             dump_ready;
  logic             dump_valid;
  logic [ID_W-1:0]  dump_id;
  logic [CNT_W-1:0] dump_exec;
  logic [CNT_W-1:0] dump_miss;
  logic [CNT_W-1:0] dump_taken;
  logic [CNT_W-1:0] total_exec;
  logic [CNT_W-1:0] total_miss;
  logic [7:0]       lost;
  logic             busy;

  always #5 clk = ~clk;

  branch_miss_profiler dut (
    .clk(clk), .reset(reset), .ev_valid(ev_valid), .branchID(branchID),
    .outcome(outcome), .miss(miss), .dump_req(dump_req), .dump_ready(dump_ready),
    .dump_valid(dump_valid), .dump_id(dump_id), .dump_exec(dump_exec),
    .dump_miss(dump_miss), .dump_taken(dump_taken), .total_exec(total_exec),
    .total_miss(total_miss), .lost(lost), .busy(busy)
  );

  typedef struct {
    int id;
    int ex;
    int ms;
    int tk;
  } entry_t;

  entry_t exp_q[$];
  int m_exec [NUM_BR];
  int m_miss [NUM_BR];
  int m_taken[NUM_BR];
  int m_tot_e, m_tot_m, m_lost;
  bit m_dumping, m_clearing;
  int left;
  bit mon_en = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  function automatic int sat(input int v, input int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_zero_counts();
    for (int i = 0; i < NUM_BR; i++) begin
      m_exec[i] = 0; m_miss[i] = 0; m_taken[i] = 0;
    end
    m_tot_e = 0; m_tot_m = 0;
  endtask

  // one clock: drive, let the edge happen, then apply the same edge to the model
  task automatic step(input bit ev, input int id, input bit oc, input bit ms,
                      input bit req, input bit rdy, input bit rst);
    ev_valid = ev; branchID = 3'(id); outcome = oc; miss = ms;
    dump_req = req; dump_ready = rdy; reset = rst;
    @(posedge clk);
    if (rst) begin
      model_zero_counts();
      m_lost = 0; exp_q.delete(); m_dumping = 0; m_clearing = 0;
    end else if (m_clearing) begin
      if (ev) m_lost = sat(m_lost, MAXL);
      model_zero_counts();
      m_clearing = 0;
    end else if (m_dumping) begin
      if (ev) m_lost = sat(m_lost, MAXL);
      if (rdy) begin
        left--;
        if (left == 0) begin m_dumping = 0; m_clearing = 1; end
      end
    end else begin
      if (ev) begin
        m_exec[id] = sat(m_exec[id], MAXC);
        m_tot_e    = sat(m_tot_e, MAXC);
        if (oc) m_taken[id] = sat(m_taken[id], MAXC);
        if (ms) begin
          m_miss[id] = sat(m_miss[id], MAXC);
          m_tot_m    = sat(m_tot_m, MAXC);
        end
      end
      if (req) begin
        for (int i = 0; i < NUM_BR; i++)
          exp_q.push_back('{id: i, ex: m_exec[i], ms: m_miss[i], tk: m_taken[i]});
        m_dumping = 1; left = NUM_BR;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // mode 0: ready held high, 1: ready 1,0,0 repeating, 2: random ready with random events
  task automatic run_dump(input int mode);
    int cyc;
    step(0, 0, 0, 0, 1, 0, 0);
    cyc = 0;
    while ((m_dumping || m_clearing) && cyc < 200) begin
      case (mode)
        0:       step(0, 0, 0, 0, 0, 1, 0);
        1:       step(0, 0, 0, 0, 0, (cyc % 3) == 0, 0);
        default: step($urandom_range(0, 1), $urandom_range(0, NUM_BR - 1),
                      $urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom_range(0, 1), $urandom_range(0, 1), 0);
      endcase
      cyc++;
    end
    check("dump_terminates", {31'd0, m_dumping || m_clearing}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("total_exec", total_exec, m_tot_e);
      check("total_miss", total_miss, m_tot_m);
      check("lost", lost, m_lost);
      check("busy", busy, m_dumping || m_clearing);
      check("dump_valid", dump_valid, m_dumping);
      if (dump_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("dump_unexpected", 1, 0);
        end else begin
          check("dump_id", dump_id, exp_q[0].id);
          check("dump_exec", dump_exec, exp_q[0].ex);
          check("dump_miss", dump_miss, exp_q[0].ms);
          check("dump_taken", dump_taken, exp_q[0].tk);
          if (dump_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bit ms5 [5];
    ms5 = '{1, 0, 1, 0, 0};
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    check("rst_dump_id", dump_id, 0);
    check("rst_dump_exec", dump_exec, 0);
    check("rst_dump_miss", dump_miss, 0);
    check("rst_dump_taken", dump_taken, 0);
    mon_en = 1'b1;

    // five events on branch 3, then a full-speed dump
    for (int i = 0; i < 5; i++) step(1, 3, 1, ms5[i], 0, 0, 0);
    idle();
    check("t1_total_exec", total_exec, 5);
    check("t1_total_miss", total_miss, 2);
    run_dump(0);
    idle();
    run_dump(0);
    run_dump(1);

    // event coincident with the request is counted; 3 in DUMP and 1 in CLEAR are lost
    for (int i = 0; i < 6; i++) step(1, i, i % 2, i % 3 == 0, 0, 0, 0);
    step(1, 2, 1, 1, 1, 0, 0);
    for (int k = 0; k < NUM_BR + 1; k++)
      step(k == 1 || k == 3 || k == 5 || k == NUM_BR, 6, 1, 1, 0, k < NUM_BR, 0);
    check("t4_lost", lost, 4);
    check("t4_busy_done", busy, 0);

    // random traffic with occasional dumps
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, NUM_BR - 1),
           $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 24) == 0, $urandom_range(0, 1), 0);
    end
    while (m_dumping || m_clearing) step(0, 0, 0, 0, 0, 1, 0);
    run_dump(2);
    run_dump(1);

    // saturation on branch 7
    for (int i = 0; i < 65540; i++) step(1, 7, $urandom_range(0, 1), 1, 0, 0, 0);
    check("sat_total_miss", total_miss, MAXC);
    check("sat_total_exec", total_exec, MAXC);
    run_dump(0);

    // reset while entry 4 is presented
    for (int i = 0; i < 20; i++) step(1, $urandom_range(0, NUM_BR - 1), 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 0);
    check("pre_rst_dump_id", dump_id, 4);
    step(0, 0, 0, 0, 0, 0, 1);
    check("post_rst_valid", dump_valid, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_total", total_exec, 0);
    idle();
    run_dump(0);
    idle();

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
